uart_rx_pkt_ctrl: RTL and testbench
===================================

Name: uart_rx_pkt_ctrl

Overview:
Packet-level controller that sits directly behind the UART receiver. It consumes the receiver's per-byte done tick and data byte, and frames them as SOF, LEN, payload and checksum. Payload bytes are buffered in a small FIFO and presented on a valid/ready stream. A one-cycle status pulse reports the outcome of every packet. An inter-byte timeout, counted on the shared 16x baud sample tick, recovers from truncated frames.

Parameters:
SOF_BYTE, 8'h7E, start-of-frame marker byte
MAX_LEN, 16, largest legal LEN value (1..255)
FIFO_DEPTH, 16, payload FIFO entries; power of two, at least 2
TIMEOUT_TICKS, 320, i_s_tick count allowed between bytes inside a frame (20 bit-times at 16 ticks/bit)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_rx_done_tick  in  1  one-cycle pulse: byte received
i_rx_data  in  8  received byte; valid when i_rx_done_tick=1
i_s_tick  in  1  16x baud sample enable, shared with the receiver
o_pkt_data  out  8  payload byte at FIFO head
o_pkt_last  out  1  head byte is the last payload byte of its packet
o_pkt_valid  out  1  FIFO not empty
i_pkt_ready  in  1  consumer accepts the head byte when valid & ready
o_done  out  1  one-cycle pulse: packet finished or aborted
o_status  out  3  qualified by o_done: 0 OK, 1 BAD_CSUM, 2 BAD_LEN, 3 TIMEOUT, 4 OVERFLOW
o_busy  out  1  state != HUNT

Behaviour:
- Reset (async, i_reset_n=0):
  - state=HUNT; FIFO empty; all counters and the checksum accumulator are 0.
  - o_pkt_valid=0, o_done=0, o_status=0, o_busy=0. o_pkt_data and o_pkt_last are don't-care while o_pkt_valid=0.
  - Reset mid-packet discards the partial frame and all FIFO contents, with no o_done.
- State transitions, all taken on a cycle with i_rx_done_tick=1:
  - HUNT: byte==SOF_BYTE -> LEN; clear acc, ovf flag, timeout counter. Any other byte is ignored.
  - LEN: store len and set acc=byte. len==0 -> CSUM. len>MAX_LEN -> HUNT with o_done, status BAD_LEN. Otherwise -> PAYLOAD with idx=0.
  - PAYLOAD: acc+=byte (mod 256); push {last=(idx==len-1), byte}; idx++. The last byte -> CSUM. SOF_BYTE has no special meaning here.
  - CSUM: -> HUNT with o_done. Status priority: OVERFLOW if ovf flag set, else BAD_CSUM if (acc+byte) mod 256 != 0, else OK.
- o_done and o_status are registered. The pulse appears the cycle after the terminating i_rx_done_tick.
- Timeout:
  - In LEN, PAYLOAD and CSUM, the counter increments on each i_s_tick and clears on each i_rx_done_tick.
  - When the counter reaches TIMEOUT_TICKS-1 and i_s_tick=1: -> HUNT with o_done, status TIMEOUT.
  - If i_rx_done_tick and the timeout expiry occur in the same cycle, the byte wins and the counter clears.
  - The counter is held at 0 in HUNT.
- FIFO:
  - 9 bits wide, synchronous; count is 0..FIFO_DEPTH.
  - Pop when o_pkt_valid & i_pkt_ready. The head is registered at the read pointer; o_pkt_valid rises the cycle after the first push.
  - Push when full with no simultaneous pop: the byte is dropped, ovf flag is set, parsing continues, and the final status is OVERFLOW.
  - Push when full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Bytes already pushed for an aborted or bad packet remain in the FIFO and drain normally. Only the last byte of a complete-length frame carries o_pkt_last=1. The consumer qualifies data using o_done/o_status.
- The consumer may back-pressure indefinitely. The parser never stalls; overflow is the only consequence.

Test Plan:
- Good frame: 7E 03 01 02 03 F7 with ready=1 -> stream 01,02,03 with last on 03; one o_done, status 0; o_busy back to 0.
- Checksum error: 7E 02 AA 55 00 -> stream AA,55 (last on 55); o_done status 1.
- Length checks: 7E 00 00 -> no stream, status 0. 7E 11 with MAX_LEN=16 -> status 2 immediately; next frame 7E 01 5A A5 parses OK.
- Noise and timeout: 13 7E ignored-noise-then-frame works. Then 7E 04 01 followed by silence of 320 i_s_ticks -> status 3, state HUNT. A byte landing on the expiry tick is accepted with no timeout.
- Overflow: ready=0, FIFO_DEPTH=16, frame LEN=16 then 7E 02 ... -> second frame's bytes dropped once full, status 4. Draining yields exactly 16 bytes in order.
- Async reset mid-PAYLOAD with FIFO non-empty -> valid=0 and done=0 immediately; a subsequent good frame passes.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkt_ctrl
// Purpose  : Frames UART bytes as SOF/LEN/payload/checksum, buffers payload in
//            a FIFO on a valid/ready stream and pulses a per-packet status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF_BYTE      = 8'h7E,
    parameter int         MAX_LEN       = 16,
    parameter int         FIFO_DEPTH    = 16,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx_done_tick,
    input  logic [7:0] i_rx_data,
    input  logic       i_s_tick,
    output logic [7:0] o_pkt_data,
    output logic       o_pkt_last,
    output logic       o_pkt_valid,
    input  logic       i_pkt_ready,
    output logic       o_done,
    output logic [2:0] o_status,
    output logic       o_busy
);

    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_tw = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_tw-1:0] c_tlast   = c_tw'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]      c_max_len = 8'(MAX_LEN);

    localparam logic [2:0] c_st_ok       = 3'd0;
    localparam logic [2:0] c_st_bad_csum = 3'd1;
    localparam logic [2:0] c_st_bad_len  = 3'd2;
    localparam logic [2:0] c_st_timeout  = 3'd3;
    localparam logic [2:0] c_st_overflow = 3'd4;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_len, w_len_nxt;
    logic [7:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_acc, w_acc_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic [c_tw-1:0] r_tcnt, w_tcnt_nxt;
    logic            r_done, w_done_nxt;
    logic [2:0]      r_status, w_status_nxt;

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic       w_push, w_push_ok, w_pop, w_full, w_last;
    logic [7:0] w_sum;
    logic [8:0] w_head;

    assign w_full    = (r_count == c_full);
    assign w_pop     = (r_count != '0) && i_pkt_ready;
    // A push into a full FIFO is only lost when the head is not leaving this cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_sum     = r_acc + i_rx_data;
    assign w_last    = (r_idx == r_len - 8'd1);

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_acc;
        w_ovf_nxt    = r_ovf;
        w_tcnt_nxt   = r_tcnt;
        w_done_nxt   = 1'b0;
        w_status_nxt = r_status;
        w_push       = 1'b0;

        case (r_state)
            ST_HUNT: begin
                w_tcnt_nxt = '0;
                if (i_rx_done_tick && i_rx_data == SOF_BYTE) begin
                    w_state_nxt = ST_LEN;
                    w_acc_nxt   = 8'd0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_LEN: begin
                if (i_rx_done_tick) begin
                    w_len_nxt = i_rx_data;
                    w_acc_nxt = i_rx_data;
                    if (i_rx_data == 8'd0) begin
                        w_state_nxt = ST_CSUM;
                    end else if (i_rx_data > c_max_len) begin
                        w_state_nxt  = ST_HUNT;
                        w_done_nxt   = 1'b1;
                        w_status_nxt = c_st_bad_len;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                        w_idx_nxt   = 8'd0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_rx_done_tick) begin
                    w_acc_nxt = w_sum;
                    w_push    = 1'b1;
                    w_idx_nxt = r_idx + 8'd1;
                    if (w_last) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            default: begin
                if (i_rx_done_tick) begin
                    w_state_nxt = ST_HUNT;
                    w_done_nxt  = 1'b1;
                    if (r_ovf) begin
                        w_status_nxt = c_st_overflow;
                    end else if (w_sum != 8'd0) begin
                        w_status_nxt = c_st_bad_csum;
                    end else begin
                        w_status_nxt = c_st_ok;
                    end
                end
            end
        endcase

        // A received byte always beats an expiring timeout on the same cycle.
        if (r_state != ST_HUNT) begin
            if (i_rx_done_tick) begin
                w_tcnt_nxt = '0;
            end else if (i_s_tick) begin
                if (r_tcnt == c_tlast) begin
                    w_state_nxt  = ST_HUNT;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = c_st_timeout;
                    w_tcnt_nxt   = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + c_tw'(1);
                end
            end
        end

        if (w_push && w_full && !w_pop) begin
            w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_HUNT;
            r_len    <= 8'd0;
            r_idx    <= 8'd0;
            r_acc    <= 8'd0;
            r_ovf    <= 1'b0;
            r_tcnt   <= '0;
            r_done   <= 1'b0;
            r_status <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_idx    <= w_idx_nxt;
            r_acc    <= w_acc_nxt;
            r_ovf    <= w_ovf_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_done   <= w_done_nxt;
            r_status <= w_status_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_last, i_rx_data};
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign o_pkt_data  = w_head[7:0];
    assign o_pkt_last  = w_head[8];
    assign o_pkt_valid = (r_count != '0);
    assign o_done      = r_done;
    assign o_status    = r_status;
    assign o_busy      = (r_state != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_pkt_ctrl
// Purpose  : Scoreboard bench for the UART packet controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;

    localparam logic [7:0] c_sof = 8'h7E;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_rx_done_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_s_tick = 1'b0;
    logic       i_pkt_ready = 1'b0;
    logic [7:0] o_pkt_data;
    logic       o_pkt_last;
    logic       o_pkt_valid;
    logic       o_done;
    logic [2:0] o_status;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_data_q[$];
    logic [2:0] exp_st_q[$];
    bit         rand_ready = 1'b0;

    uart_rx_pkt_ctrl #(
        .SOF_BYTE      (8'h7E),
        .MAX_LEN       (16),
        .FIFO_DEPTH    (16),
        .TIMEOUT_TICKS (320)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .i_s_tick       (i_s_tick),
        .o_pkt_data     (o_pkt_data),
        .o_pkt_last     (o_pkt_last),
        .o_pkt_valid    (o_pkt_valid),
        .i_pkt_ready    (i_pkt_ready),
        .o_done         (o_done),
        .o_status       (o_status),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // One clock cycle: sample on the falling edge against the scoreboard.
    task automatic step();
        logic [8:0] e;
        logic [2:0] s;
        if (rand_ready) i_pkt_ready = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        if (o_pkt_valid && i_pkt_ready) begin
            n_checks++;
            if (exp_data_q.size() == 0) begin
                n_errors++;
                $display("FAIL stream_extra: got last=%0b data=%h, expected no byte", o_pkt_last, o_pkt_data);
            end else begin
                e = exp_data_q.pop_front();
                if ({o_pkt_last, o_pkt_data} !== e) begin
                    n_errors++;
                    $display("FAIL stream_byte: got last=%0b data=%h, expected last=%0b data=%h",
                             o_pkt_last, o_pkt_data, e[8], e[7:0]);
                end
            end
        end
        if (o_done) begin
            n_checks++;
            if (exp_st_q.size() == 0) begin
                n_errors++;
                $display("FAIL done_extra: got status=%0d, expected no done", o_status);
            end else begin
                s = exp_st_q.pop_front();
                if (o_status !== s) begin
                    n_errors++;
                    $display("FAIL done_status: got %0d, expected %0d", o_status, s);
                end
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        step();
        i_rx_done_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            i_s_tick = 1'b1;
            step();
        end
        i_s_tick = 1'b0;
    endtask

    // Payload byte i is seed+i; checksum makes LEN+payload+CSUM sum to zero.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] seed,
                              input logic [2:0] st, input bit record);
        logic [7:0] sum;
        logic [7:0] b;
        sum = len;
        send_byte(c_sof);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b   = seed + 8'(i);
            sum = sum + b;
            if (record) exp_data_q.push_back({(i == int'(len) - 1), b});
            send_byte(b);
        end
        exp_st_q.push_back(st);
        send_byte(8'h00 - sum);
    endtask

    task automatic wait_drain();
        i_pkt_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_data_q.size() != 0 || exp_st_q.size() != 0); i++) step();
        n_checks++;
        if (exp_data_q.size() != 0 || exp_st_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: bytes left=%0d dones left=%0d, expected 0 0",
                     exp_data_q.size(), exp_st_q.size());
        end
        repeat (4) step();
        n_checks++;
        if (o_pkt_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after: got valid=%0b busy=%0b, expected 0 0", o_pkt_valid, o_busy);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) step();
        n_checks++;
        if (o_pkt_valid !== 1'b0 || o_done !== 1'b0 || o_status !== 3'd0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%0b done=%0b status=%0d busy=%0b, expected 0 0 0 0",
                     o_pkt_valid, o_done, o_status, o_busy);
        end
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_good_frame();
        i_pkt_ready = 1'b1;
        exp_data_q.push_back({1'b0, 8'h01});
        exp_data_q.push_back({1'b0, 8'h02});
        exp_data_q.push_back({1'b1, 8'h03});
        send_byte(8'h7E);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_sof: got %0b, expected 1", o_busy);
        end
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        exp_st_q.push_back(3'd0);
        send_byte(8'hF7);
        wait_drain();
    endtask

    task automatic test_bad_csum();
        exp_data_q.push_back({1'b0, 8'hAA});
        exp_data_q.push_back({1'b1, 8'h55});
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h55);
        exp_st_q.push_back(3'd1);
        send_byte(8'h00);
        wait_drain();
    endtask

    task automatic test_length();
        send_byte(8'h7E);
        send_byte(8'h00);
        exp_st_q.push_back(3'd0);
        send_byte(8'h00);
        wait_drain();
        send_byte(8'h7E);
        exp_st_q.push_back(3'd2);
        send_byte(8'h11);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_len_state: got busy=%0b, expected 0", o_busy);
        end
        send_frame(8'd1, 8'h5A, 3'd0, 1'b1);
        send_frame(8'd16, 8'h30, 3'd0, 1'b1);
        wait_drain();
    endtask

    task automatic test_noise_timeout();
        send_byte(8'h13);
        send_frame(8'd4, 8'h7C, 3'd0, 1'b1);
        wait_drain();
        exp_data_q.push_back({1'b0, 8'h01});
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        ticks(319);
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_early: got busy=%0b done=%0b, expected 1 0", o_busy, o_done);
        end
        exp_st_q.push_back(3'd3);
        ticks(1);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_state: got busy=%0b, expected 0", o_busy);
        end
        wait_drain();
        exp_data_q.push_back({1'b0, 8'h01});
        exp_data_q.push_back({1'b0, 8'h02});
        exp_data_q.push_back({1'b0, 8'h03});
        exp_data_q.push_back({1'b1, 8'h04});
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        ticks(319);
        i_s_tick = 1'b1;
        send_byte(8'h02);
        i_s_tick = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL expiry_byte_wins: got busy=%0b, expected 1", o_busy);
        end
        ticks(319);
        send_byte(8'h03);
        send_byte(8'h04);
        exp_st_q.push_back(3'd0);
        send_byte(8'hF2);
        wait_drain();
    endtask

    task automatic test_overflow();
        i_pkt_ready = 1'b0;
        send_frame(8'd16, 8'h20, 3'd0, 1'b1);
        send_frame(8'd2, 8'hA1, 3'd4, 1'b0);
        step();
        n_checks++;
        if (o_pkt_valid !== 1'b1 || exp_data_q.size() != 16) begin
            n_errors++;
            $display("FAIL overflow_hold: got valid=%0b pending=%0d, expected 1 16",
                     o_pkt_valid, exp_data_q.size());
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        i_pkt_ready = 1'b0;
        send_byte(8'h7E);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        n_checks++;
        if (o_pkt_valid !== 1'b1 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: got valid=%0b busy=%0b, expected 1 1", o_pkt_valid, o_busy);
        end
        #2 i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_pkt_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%0b done=%0b busy=%0b, expected 0 0 0",
                     o_pkt_valid, o_done, o_busy);
        end
        step();
        i_reset_n = 1'b1;
        step();
        i_pkt_ready = 1'b1;
        send_frame(8'd2, 8'h40, 3'd0, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        send_frame(8'd5, 8'h61, 3'd0, 1'b1);
        send_frame(8'd5, 8'hF0, 3'd0, 1'b1);
        send_frame(8'd5, 8'h08, 3'd0, 1'b1);
        rand_ready = 1'b0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_length();
        test_noise_timeout();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
